// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle ops plus a WIDTH-cycle shift-add multiplier
// Results and flags are registered and held until the consumer takes them.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             of_flag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, HOLD} state_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               cf_q, zf_q, sf_q, of_q;
  logic               out_valid_q, busy_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;

  logic [WIDTH-1:0]   res_d;
  logic               cf_d, of_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] rot_l, rot_r;
  logic               accept;

  assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  // Rotating a doubled copy keeps the rotate free of a variable-width complement shift.
  assign rot_l = {a, a} << b[SHW-1:0];
  assign rot_r = {a, a} >> b[SHW-1:0];

  always_comb begin
    res_d = '0;
    cf_d  = 1'b0;
    of_d  = 1'b0;
    case (op)
      OP_ADD: begin
        res_d = sum[WIDTH-1:0];
        cf_d  = sum[WIDTH];
        of_d  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff[WIDTH-1:0];
        cf_d  = diff[WIDTH];
        of_d  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_NOT: res_d = ~a;
      OP_SLL: res_d = a << b;
      OP_SRL: res_d = a >> b;
      OP_SRA: res_d = $signed(a) >>> b;
      OP_ROL: res_d = rot_l[2*WIDTH-1:WIDTH];
      OP_ROR: res_d = rot_r[WIDTH-1:0];
      default: res_d = '0;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        MUL_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_q     <= HOLD;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= acc_d[WIDTH-1:0];
            cf_q        <= |acc_d[2*WIDTH-1:WIDTH];
            zf_q        <= (acc_d[WIDTH-1:0] == '0);
            sf_q        <= acc_d[WIDTH-1];
            of_q        <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q     <= MUL_RUN;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
              acc_q       <= '0;
              mcand_q     <= {{WIDTH{1'b0}}, a};
              mplier_q    <= b;
              cnt_q       <= '0;
            end else begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              cf_q        <= cf_d;
              zf_q        <= (res_d == '0);
              sf_q        <= res_d[WIDTH-1];
              of_q        <= of_d;
            end
          end else if (state_q == HOLD && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of_flag   = of_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cf, zf, sf, of_flag, busy;
  logic [15:0] result;

  int vectors = 0;
  int miscompares = 0;

  bit          mdl_on = 1'b0;
  bit          have_out, known;
  int          mul_left;
  logic [19:0] exp_q, pend;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cf(cf), .zf(zf), .sf(sf), .of_flag(of_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed as {cf, zf, sf, of, result[15:0]}.
  function automatic logic [19:0] ref_alu(input logic [3:0] o, input int unsigned x, input int unsigned y);
    int unsigned r;
    bit          c, v;
    int          sx, sy, s, sh;
    longint      p;
    logic [15:0] rr;
    c = 0; v = 0; r = 0;
    sx = (x >= 32768) ? int'(x) - 65536 : int'(x);
    sy = (y >= 32768) ? int'(y) - 65536 : int'(y);
    case (o)
      4'd1: begin r = (x + y) % 65536; c = (x + y) > 65535; s = sx + sy; v = (s > 32767) || (s < -32768); end
      4'd2: begin r = (x + 65536 - y) % 65536; c = x < y; s = sx - sy; v = (s > 32767) || (s < -32768); end
      4'd3: r = x & y;
      4'd4: r = x | y;
      4'd5: r = x ^ y;
      4'd6: r = 65535 - x;
      4'd7: r = (y >= 16) ? 0 : (x * (1 << y)) % 65536;
      4'd8: r = (y >= 16) ? 0 : x / (1 << y);
      4'd9: begin
        if (y >= 16) r = (sx < 0) ? 65535 : 0;
        else begin s = sx >>> y; r = (s + 65536) % 65536; end
      end
      4'd10: begin sh = y % 16; r = ((x << sh) | (x >> (16 - sh))) % 65536; end
      4'd11: begin sh = y % 16; r = ((x >> sh) | (x << (16 - sh))) % 65536; end
      4'd12: begin p = longint'(x) * longint'(y); r = p % 65536; c = p > 65535; end
      default: r = 0;
    endcase
    rr = r[15:0];
    return {c, rr == 16'h0, rr[15], v, rr};
  endfunction

  always @(posedge clk) begin : model
    bit          take;
    logic [19:0] r;
    if (rst) begin
      mdl_on = 1'b1; have_out = 1'b0; mul_left = 0; known = 1'b1; exp_q = 20'h0;
    end else if (mdl_on) begin
      take = in_valid && ((mul_left == 0 && !have_out) || (have_out && out_ready));
      r = ref_alu(op, a, b);
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin have_out = 1'b1; exp_q = pend; known = 1'b1; end
      end else if (have_out && out_ready && !take) begin
        have_out = 1'b0; known = 1'b0;
      end
      if (take) begin
        if (op == 4'd12) begin mul_left = 16; have_out = 1'b0; known = 1'b0; pend = r; end
        else begin have_out = 1'b1; exp_q = r; known = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("in_ready", 32'(in_ready), 32'((mul_left == 0 && !have_out) || (have_out && out_ready)));
      chk("out_valid", 32'(out_valid), 32'(have_out));
      chk("busy", 32'(busy), 32'(mul_left > 0));
      if (known) chk("result_flags", 32'({cf, zf, sf, of_flag, result}), 32'(exp_q));
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] o,
                      input logic [15:0] x, input logic [15:0] y, input logic ordy);
    rst = r; in_valid = v; op = o; a = x; b = y; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 4'd0; a = 16'h0; b = 16'h0; out_ready = 1'b0;

    chk("pin_add", 32'(ref_alu(4'd1, 16'hFFFF, 16'h0001)), 32'h0C0000);
    chk("pin_sub_ov", 32'(ref_alu(4'd2, 16'h8000, 16'h0001)), 32'h017FFF);
    chk("pin_sub_bw", 32'(ref_alu(4'd2, 16'h0001, 16'h0002)), 32'h0AFFFF);
    chk("pin_mul", 32'(ref_alu(4'd12, 16'h0100, 16'h0100)), 32'h0C0000);
    chk("pin_sra", 32'(ref_alu(4'd9, 16'h8000, 16'd20)), 32'h02FFFF);
    chk("pin_sll", 32'(ref_alu(4'd7, 16'h0001, 16'd16)), 32'h040000);
    chk("pin_rol", 32'(ref_alu(4'd10, 16'h8001, 16'd17)), 32'h000003);
    chk("pin_ror", 32'(ref_alu(4'd11, 16'h0001, 16'd1)), 32'h028000);

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 4'd1, 16'hFFFF, 16'h0001, 1);
    chk("add_literal", 32'({out_valid, cf, zf, sf, of_flag, result}), 32'h1C0000);
    step(0, 1, 4'd2, 16'h8000, 16'h0001, 1);
    step(0, 1, 4'd2, 16'h0001, 16'h0002, 1);
    step(0, 1, 4'd9, 16'h8000, 16'd20, 1);
    step(0, 1, 4'd7, 16'h0001, 16'd16, 1);
    step(0, 1, 4'd10, 16'h8001, 16'd17, 1);
    step(0, 1, 4'd11, 16'h0001, 16'd1, 1);
    step(0, 0, 0, 0, 0, 1);

    step(0, 1, 4'd12, 16'h0100, 16'h0100, 1);
    for (int i = 0; i < 18; i++) step(0, 1, 4'd1, 16'h1234, 16'h1111, (i > 16));
    step(0, 0, 0, 0, 0, 1);

    step(0, 1, 4'd3, 16'hF0F0, 16'h3C3C, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 4'd4, 16'h0F00, 16'h00F0, 0);
    step(0, 1, 4'd4, 16'h0F00, 16'h00F0, 1);
    step(0, 0, 0, 0, 0, 1);

    step(0, 1, 4'd12, 16'h1234, 16'h0F0F, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_mid_mul", 32'({out_valid, busy, in_ready, result}), 32'h10000);
    step(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           4'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath width in bits; legal values: powers of two from 8 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning rotate-amount width; not overridden by users.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port op  input  4  opcode.
REQ-008 SHALL have ports a and b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports cf, zf, sf, of_flag  output  1 each  registered carry/borrow, zero, sign and signed-overflow flags.
REQ-013 SHALL have port busy  output  1  a MUL is in progress.

Function
REQ-014 SHALL implement states IDLE, MUL_RUN, HOLD.
- Accept: in_valid && in_ready at a rising edge.
REQ-015 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready).
- This is the only combinational input-to-output path.
REQ-016 SHALL, on accepting a single-cycle op, register result and flags at that edge and enter HOLD.
- out_valid=1 in the following cycle (latency 1).
REQ-017 SHALL, on accepting MUL (4'b1100), latch a and b, enter MUL_RUN and hold busy=1 for exactly WIDTH cycles.
- Computes a shift-add product, one bit per cycle.
- Enters HOLD at edge N+WIDTH, where N is the accept edge.
REQ-018 SHALL hold result, flags and out_valid stable while in HOLD and out_ready=0.
REQ-019 SHALL leave HOLD on out_ready=1.
- If a request is accepted in that same cycle, it is processed as from IDLE (back-to-back; throughput 1 per cycle for single-cycle ops).
- Otherwise go to IDLE with out_valid=0.
REQ-020 SHALL ignore in_valid while in MUL_RUN, and in HOLD while out_ready=0.
REQ-021 SHALL decode single-cycle opcodes as:
- 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT (~a)
- 0111 SLL, 1000 SRL, 1001 SRA, 1010 ROL, 1011 ROR
- any other opcode: NOP with result 0
REQ-022 SHALL compute ADD cf as the carry out of the unsigned (WIDTH+1)-bit sum.
REQ-023 SHALL compute SUB cf as the borrow: 1 iff a<b unsigned.
REQ-024 SHALL set of_flag for ADD when a and b have equal sign bits and the result sign differs from them.
REQ-025 SHALL set of_flag for SUB when a and b have different sign bits and the result sign differs from a.
REQ-026 SHALL shift using the full b value for SLL, SRL and SRA.
- b>=WIDTH gives 0 for SLL/SRL.
- b>=WIDTH gives WIDTH copies of a[WIDTH-1] for SRA.
REQ-027 SHALL rotate ROL/ROR by b[SHW-1:0], i.e. b mod WIDTH; amount 0 returns a.
REQ-028 SHALL output the low WIDTH bits of the 2*WIDTH product for MUL (unsigned).
- cf=1 iff the high WIDTH bits are nonzero.
- of_flag=0.
REQ-029 SHALL clear cf and of_flag for logic, shift, rotate and NOP ops.
REQ-030 SHALL set, for every op, zf=(result==0) and sf=result[WIDTH-1].

Reset
REQ-031 SHALL, while rst=1 at a rising edge, enter IDLE with out_valid=0, busy=0, result=0 and cf=zf=sf=of_flag=0.
REQ-032 SHALL, on rst during MUL_RUN or HOLD, discard the pending operation with no output produced.
- in_ready=1 in the cycle after the reset edge, with rst low.
REQ-033 SHALL give rst priority over any simultaneous accept.

Verification (WIDTH=16)
REQ-034 SHALL pass: ADD a=0xFFFF, b=0x0001 -> result=0x0000, cf=1, zf=1, sf=0, of_flag=0; out_valid asserted the cycle after accept.
REQ-035 SHALL pass SUB cases:
- a=0x8000, b=0x0001 -> 0x7FFF, of_flag=1, cf=0.
- a=0x0001, b=0x0002 -> 0xFFFF, cf=1, sf=1.
REQ-036 SHALL pass: MUL a=0x0100, b=0x0100 -> result=0x0000, cf=1, zf=1.
- busy=1 and in_ready=0 for 16 cycles.
- out_valid at accept+16.
REQ-037 SHALL pass shift cases:
- SRA 0x8000 by 20 -> 0xFFFF.
- SLL 0x0001 by 16 -> 0x0000.
- ROL 0x8001 by 17 -> 0x0003.
- ROR 0x0001 by 1 -> 0x8000.
REQ-038 SHALL pass backpressure: out_ready=0 for 3 cycles after an AND -> result and flags unchanged and in_ready=0 throughout; then out_ready=1 with in_valid=1 (OR) -> new op accepted that cycle and new result valid next cycle.
REQ-039 SHALL pass: rst=1 at cycle 5 of a MUL -> next cycle out_valid=0, busy=0, result=0, in_ready=1.
